// File: rtl/osd_pkg.sv
// Shared types and constants for the OSD tile-map controller.
package osd_pkg;

  localparam int TILE_W = 9;
  localparam int CELL_W = 12;

  localparam logic [7:0] ADDR_ENABLE_DEF  = 8'hFE;
  localparam logic [7:0] ADDR_DISPLAY_DEF = 8'hFD;

  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [CELL_W:0]   cell_lim_t;
  typedef logic [TILE_W-1:0] tile_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } fill_state_e;

endpackage

// File: rtl/osd_fill_seq.sv
// Screen-fill sequencer: walks every tile cell once with a latched {inv,char},
// requesting the tile port each cycle and advancing only when granted.
module osd_fill_seq
  import osd_pkg::*;
#(
  parameter int C_CELLS   = 1280,
  parameter bit C_INVERSE = 1'b1
) (
  input  logic       clk_pixel,
  input  logic       resetn,
  input  logic       i_start,
  input  logic [7:0] i_char,
  input  logic       i_inv,
  input  logic       i_gnt,
  output logic       o_req,
  output cell_t      o_cell,
  output tile_t      o_data,
  output logic       o_idle,
  output logic       o_busy,
  output logic       o_done
);

  fill_state_e r_state;
  fill_state_e w_state_nxt;
  cell_t       r_cell;
  tile_t       r_data;
  logic        r_busy;
  logic        r_done;
  logic        w_last;

  assign w_last = (r_cell == cell_t'(C_CELLS - 1));

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_FILL;
      S_FILL:  if (i_gnt && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cell  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_FILL);
      r_done  <= (w_state_nxt == S_DONE);
      if (r_state == S_IDLE && i_start) begin
        r_cell <= '0;
        r_data <= {C_INVERSE & i_inv, i_char};
      end else if (r_state == S_FILL && i_gnt) begin
        r_cell <= r_cell + 1'b1;
      end
    end
  end

  assign o_req  = (r_state == S_FILL);
  assign o_idle = (r_state == S_IDLE);
  assign o_cell = r_cell;
  assign o_data = r_data;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/osd_tile_ctrl.sv
// OSD tile-map write arbiter (SPI > fill > host) plus overlay enable register.
// Fill engine present only when OSD_TILE_CTRL_FILL_EN is defined.
module osd_tile_ctrl
  import osd_pkg::*;
#(
  parameter logic [7:0] C_ADDR_ENABLE  = ADDR_ENABLE_DEF,
  parameter logic [7:0] C_ADDR_DISPLAY = ADDR_DISPLAY_DEF,
  parameter int         C_CHARS_X      = 64,
  parameter int         C_CHARS_Y      = 20,
  parameter bit         C_INIT_ON      = 1'b1,
  parameter bit         C_INVERSE      = 1'b1
) (
  input  logic        clk_pixel,
  input  logic        resetn,
  input  logic        spi_wr,
  input  logic [31:0] spi_addr,
  input  logic [7:0]  spi_data,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [11:0] h_addr,
  input  logic [7:0]  h_char,
  input  logic        h_inv,
  input  logic        fill_start,
  input  logic [7:0]  fill_char,
  input  logic        fill_inv,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        tw_en,
  output logic [11:0] tw_addr,
  output logic [8:0]  tw_data,
  output logic        osd_en
);

  localparam int        N       = C_CHARS_X * C_CHARS_Y;
  localparam cell_lim_t N_LIMIT = cell_lim_t'(N);

  logic  r_tw_en;
  cell_t r_tw_addr;
  tile_t r_tw_data;
  logic  r_osd_en;

  logic  w_spi_disp;
  logic  w_spi_enable;
  logic  w_host_ok;
  logic  w_fill_req;
  cell_t w_fill_cell;
  tile_t w_fill_data;
  logic  w_wr_en;
  cell_t w_wr_addr;
  tile_t w_wr_data;
  logic  w_unused_addr;

  assign w_unused_addr = ^{spi_addr[23:17], spi_addr[15:12]};

  assign w_spi_disp   = spi_wr && (spi_addr[31:24] == C_ADDR_DISPLAY)
                        && ({1'b0, spi_addr[11:0]} < N_LIMIT);
  assign w_spi_enable = spi_wr && (spi_addr[31:24] == C_ADDR_ENABLE);
  assign w_host_ok    = ({1'b0, h_addr} < N_LIMIT);

`ifdef OSD_TILE_CTRL_FILL_EN
  logic w_fill_idle;

  osd_fill_seq #(
    .C_CELLS   (N),
    .C_INVERSE (C_INVERSE)
  ) u_fill (
    .clk_pixel (clk_pixel),
    .resetn    (resetn),
    .i_start   (fill_start),
    .i_char    (fill_char),
    .i_inv     (fill_inv),
    .i_gnt     (!spi_wr),
    .o_req     (w_fill_req),
    .o_cell    (w_fill_cell),
    .o_data    (w_fill_data),
    .o_idle    (w_fill_idle),
    .o_busy    (fill_busy),
    .o_done    (fill_done)
  );

  // A fill request in an idle cycle pre-empts the host in that same cycle.
  assign h_ready = !spi_wr && w_fill_idle && !fill_start;
`else
  logic w_unused_fill;

  assign w_unused_fill = ^{fill_start, fill_char, fill_inv};
  assign w_fill_req    = 1'b0;
  assign w_fill_cell   = '0;
  assign w_fill_data   = '0;
  assign fill_busy     = 1'b0;
  assign fill_done     = 1'b0;
  assign h_ready       = !spi_wr;
`endif

  // Any spi_wr owns the port for its cycle, even one that is discarded.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_tw_addr;
    w_wr_data = r_tw_data;
    if (spi_wr) begin
      if (w_spi_disp) begin
        w_wr_en   = 1'b1;
        w_wr_addr = spi_addr[11:0];
        w_wr_data = {C_INVERSE & spi_addr[16], spi_data};
      end
    end else if (w_fill_req) begin
      w_wr_en   = 1'b1;
      w_wr_addr = w_fill_cell;
      w_wr_data = w_fill_data;
    end else if (h_valid && h_ready && w_host_ok) begin
      w_wr_en   = 1'b1;
      w_wr_addr = h_addr;
      w_wr_data = {C_INVERSE & h_inv, h_char};
    end
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      r_tw_en   <= 1'b0;
      r_tw_addr <= '0;
      r_tw_data <= '0;
      r_osd_en  <= C_INIT_ON;
    end else begin
      r_tw_en   <= w_wr_en;
      r_tw_addr <= w_wr_addr;
      r_tw_data <= w_wr_data;
      if (w_spi_enable) r_osd_en <= spi_data[0];
    end
  end

  assign tw_en   = r_tw_en;
  assign tw_addr = r_tw_addr;
  assign tw_data = r_tw_data;
  assign osd_en  = r_osd_en;

endmodule
